// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: FSM states, PC step and next-PC source encoding shared by pc_gen (rev 1.0).
`default_nettype none

package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_INC   = 2'd1,
    SEL_REDIR = 2'd2,
    SEL_TRAP  = 2'd3
  } pc_sel_t;

  // Fixed priority: trap > redirect > stall > increment.
  function automatic pc_sel_t pc_sel(input logic trap, input logic redirect, input logic stall);
    if (trap)          return SEL_TRAP;
    else if (redirect) return SEL_REDIR;
    else if (stall)    return SEL_HOLD;
    else               return SEL_INC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_hist_shift.sv
// pc_hist_shift: DEPTH-stage delay line of issued PCs with a valid bit per entry (rev 1.0).
`default_nettype none

module pc_hist_shift #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic                    valid_i,
  output logic [DEPTH*XLEN-1:0]   hist_pc_o,
  output logic [DEPTH-1:0]        hist_valid_o
);

  logic [DEPTH-1:0][XLEN-1:0] pc_q;
  logic [DEPTH-1:0]           valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= '0;
      valid_q <= '0;
    end else if (shift_en_i) begin
      pc_q[0]    <= pc_i;
      valid_q[0] <= valid_i;
      for (int k = 1; k < DEPTH; k++) begin
        pc_q[k]    <= pc_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  assign hist_pc_o    = pc_q;
  assign hist_valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with trap/redirect priority, stall hold and PC history (rev 1.0).
// Optional target alignment check enabled by defining PC_GEN_MISALIGN_CHECK_EN.
`default_nettype none

module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              HIST_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_addr,
  input  logic                       trap,
  input  logic [XLEN-1:0]            trap_vec,
  output logic [XLEN-1:0]            pc_out,
  output logic                       pc_valid,
  output logic [HIST_DEPTH*XLEN-1:0] hist_pc,
  output logic [HIST_DEPTH-1:0]      hist_valid,
  output logic                       misalign_err
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  pc_sel_t         w_sel;
  logic            w_shift_en;
  logic            w_squash;
  logic [XLEN-1:0] w_raw_tgt;
  logic [XLEN-1:0] w_tgt;

  assign w_raw_tgt = trap ? trap_vec : redirect_addr;

`ifdef PC_GEN_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign w_tgt      = {w_raw_tgt[XLEN-1:2], 2'b00};
  assign misalign_d = w_squash & (|w_raw_tgt[1:0]);

  always_ff @(posedge clk) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`else
  assign w_tgt        = w_raw_tgt;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    w_sel      = SEL_HOLD;
    w_shift_en = 1'b0;
    w_squash   = 1'b0;
    case (state_q)
      // Boot cycle re-presents RESET_VEC as the first valid fetch; inputs are ignored.
      BOOT: state_d = RUN;
      RUN, HOLD: begin
        w_sel = pc_sel(trap, redirect, stall);
        case (w_sel)
          SEL_TRAP, SEL_REDIR: begin
            pc_d       = w_tgt;
            state_d    = RUN;
            w_shift_en = 1'b1;
            w_squash   = 1'b1;
          end
          SEL_HOLD: state_d = HOLD;
          default: begin
            pc_d       = pc_q + XLEN'(PC_STEP);
            state_d    = RUN;
            w_shift_en = 1'b1;
          end
        endcase
      end
      default: state_d = BOOT;
    endcase
    pc_valid_d = (state_d != BOOT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  // Wrong-path fetch behind a redirect/trap enters history marked invalid.
  pc_hist_shift #(
    .XLEN  (XLEN),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk          (clk),
    .rst          (rst),
    .shift_en_i   (w_shift_en),
    .pc_i         (pc_q),
    .valid_i      (pc_valid_q & ~w_squash),
    .hist_pc_o    (hist_pc),
    .hist_valid_o (hist_valid)
  );

  assign pc_out   = pc_q;
  assign pc_valid = pc_valid_q;

endmodule

`default_nettype wire
